// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the load/store initiator.
package mem_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // FSM state encoding
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StRmwRd = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StResp  = 3'd4;
  localparam logic [2:0] StFault = 3'd5;

  // Byte-enable mask of the lanes touched by an aligned access
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] m;
    unique case (size)
      SZ_BYTE: m = 4'b0001 << lo;
      SZ_HALF: m = lo[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Illegal size or an address not aligned to the access size
  function automatic logic access_fault(input logic [1:0] size, input logic [1:0] lo);
    return (size == SZ_ILL) ||
           ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mau_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lane_data;
  logic [3:0]  be;

  // Pick the addressed lane out of the read word and extend it
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    unique case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    unique case (size)
      SZ_BYTE: load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Replicate store data across lanes, then replace only the enabled bytes
  always_comb begin
    be        = lane_mask(size, addr_lo);
    lane_data = wdata;
    merged    = rdata;
    unique case (size)
      SZ_BYTE: lane_data = {4{wdata[7:0]}};
      SZ_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: sequences Dmem reads/writes for byte/half/word accesses.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_done,
  output logic              resp_fault,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_read,
  output logic              dmem_write,
  input  logic [DATA_W-1:0] dmem_rdata
);

  logic [2:0]        state_q, state_d;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              req_fault;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign accept    = req_valid && (state_q == StIdle);
  assign req_fault = access_fault(req_size, req_addr[1:0]);

  mau_lane_align u_lane_align (
    .size      (size_q),
    .sign_ext  (signed_q),
    .addr_lo   (addr_q[1:0]),
    .rdata     (dmem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  // Next-state decode; routing is fixed at accept from the live request
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_fault)               state_d = StFault;
          else if (!req_store)         state_d = StLoad;
          else if (req_size == SZ_WORD) state_d = StWrite;
          else                         state_d = StRmwRd;
        end
      end
      StLoad:  state_d = StResp;
      StRmwRd: state_d = StWrite;
      StWrite: state_d = StResp;
      StResp:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and request latches; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // Sub-word store: wdata_q becomes the full word to write back
      if (state_q == StRmwRd) wdata_q <= merged;
      if (state_q == StLoad)  rdata_q <= load_data;
    end
  end

  // Outputs decoded from registered state only, so no request-to-Dmem path
  always_comb begin
    req_ready  = (state_q == StIdle);
    dmem_read  = (state_q == StLoad) || (state_q == StRmwRd);
    dmem_write = (state_q == StWrite);
    resp_done  = (state_q == StResp) || (state_q == StFault);
    resp_fault = (state_q == StFault);
    resp_rdata = rdata_q;
    dmem_addr  = '0;
    dmem_wdata = '0;
    if (state_q != StIdle) begin
      dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      dmem_wdata = wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word-wide Dmem model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_store, req_signed;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, resp_done, resp_fault;
  logic [31:0] resp_rdata;
  logic [13:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_read, dmem_write;
  wire  [31:0] dmem_rdata;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pl_en;
  logic [11:0] pl_idx;
  logic [31:0] pl_data;
  logic [31:0] m_rdata;

  int checks = 0, errors = 0;
  int rd_cnt = 0, wr_cnt = 0, acc_cnt = 0, both_cnt = 0;

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [13:0] a;
    logic [31:0] wd;
    logic        ef;
    int          el;
    logic [31:0] er;
  } vec_t;
  vec_t vt[16];

  mem_access_unit #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_done  (resp_done),
    .resp_fault (resp_fault),
    .resp_rdata (resp_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Dmem: combinational read, posedge write, plus a preload port
  assign dmem_rdata = dmem_read ? mem[dmem_addr[13:2]] : 32'hzzzz_zzzz;
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dmem_write) mem[dmem_addr[13:2]] <= dmem_wdata;
  end

  // Activity counters
  always @(posedge clk) begin
    if (dmem_read) rd_cnt <= rd_cnt + 1;
    if (dmem_write) wr_cnt <= wr_cnt + 1;
    if (dmem_read && dmem_write) both_cnt <= both_cnt + 1;
    if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  // Reference rules, written as plain arithmetic on whole words
  function automatic logic model_fault(input logic [1:0] sz, input logic [13:0] a);
    int unsigned ai = a;
    return (sz == 2'd3) || (sz == 2'd1 && ai % 2 != 0) || (sz == 2'd2 && ai % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [13:0] a);
    int unsigned ai = a;
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * (ai % 4))) & 32'hFF;
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * ((ai / 2) % 2))) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [13:0] a, input logic [31:0] wd);
    int unsigned ai = a;
    int unsigned sh;
    logic [31:0] mask;
    if (sz == 2'd0) begin
      sh = 8 * (ai % 4); mask = 32'hFF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * ((ai / 2) % 2); mask = 32'hFFFF << sh;
    end else begin
      sh = 0; mask = 32'hFFFF_FFFF;
    end
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  // Apply one request; must be called #1 after a posedge
  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [13:0] a, input logic [31:0] wd,
                        output int lat, output logic flt, output logic [31:0] rd,
                        output int nrd, output int nwr);
    int n = 0;
    int r0, w0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    r0 = rd_cnt; w0 = wr_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_done && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    flt = resp_fault;
    rd  = resp_rdata;
    @(posedge clk); #1;
    nrd = rd_cnt - r0;
    nwr = wr_cnt - w0;
  endtask

  // Update reference state after a request completes
  task automatic model_apply(input logic st, input logic [1:0] sz, input logic sg,
                             input logic [13:0] a, input logic [31:0] wd);
    if (!model_fault(sz, a)) begin
      if (st) ref_mem[a[13:2]] = model_store(ref_mem[a[13:2]], sz, a, wd);
      else m_rdata = model_load(ref_mem[a[13:2]], sz, sg, a);
    end
  endtask

  // Full check of one request against the reference model
  task automatic run_model(input string nm, input logic st, input logic [1:0] sz,
                           input logic sg, input logic [13:0] a, input logic [31:0] wd);
    logic        ef;
    int          el, erd, ewr, lat, nrd, nwr;
    logic        flt;
    logic [31:0] rd;
    ef  = model_fault(sz, a);
    el  = ef ? 1 : (!st || sz == 2'd2) ? 2 : 3;
    erd = (!ef && (!st || sz != 2'd2)) ? 1 : 0;
    ewr = (!ef && st) ? 1 : 0;
    model_apply(st, sz, sg, a, wd);
    do_req(st, sz, sg, a, wd, lat, flt, rd, nrd, nwr);
    chk({nm, "_lat"}, lat, el);
    chk({nm, "_fault"}, {31'd0, flt}, {31'd0, ef});
    chk({nm, "_rdata"}, rd, m_rdata);
    chk({nm, "_reads"}, nrd, erd);
    chk({nm, "_writes"}, nwr, ewr);
  endtask

  initial begin
    int          lat, nrd, nwr, a0, w0;
    logic        flt;
    logic [31:0] rd;
    logic [11:0] idx;
    logic [13:0] ra;

    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; pl_en = 1'b0;
    pl_idx = '0; pl_data = '0; m_rdata = '0;

    // Preload low region, top word, and the known word at 0x100
    for (int i = 0; i < 129; i++) begin
      idx = (i == 128) ? 12'hFFF : 12'(i);
      pl_en = 1'b1; pl_idx = idx;
      pl_data = (idx == 12'h040) ? 32'h8877_66F0 : $urandom;
      ref_mem[idx] = pl_data;
      @(posedge clk); #1;
    end
    pl_en = 1'b0;
    chk("rst_hold_read", {31'd0, dmem_read}, 32'd0);
    chk("rst_hold_write", {31'd0, dmem_write}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_done", {31'd0, resp_done}, 32'd0);
    chk("rst_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_addr", {18'd0, dmem_addr}, 32'd0);

    // Directed table
    vt[0]  = '{1'b0, 2'd0, 1'b1, 14'h100, 32'h0, 1'b0, 2, 32'hFFFF_FFF0};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 14'h100, 32'h0, 1'b0, 2, 32'h0000_00F0};
    vt[2]  = '{1'b0, 2'd1, 1'b1, 14'h102, 32'h0, 1'b0, 2, 32'hFFFF_8877};
    vt[3]  = '{1'b0, 2'd1, 1'b0, 14'h102, 32'h0, 1'b0, 2, 32'h0000_8877};
    vt[4]  = '{1'b0, 2'd2, 1'b0, 14'h100, 32'h0, 1'b0, 2, 32'h8877_66F0};
    vt[5]  = '{1'b1, 2'd0, 1'b0, 14'h101, 32'h1234_56AB, 1'b0, 3, 32'h8877_66F0};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 14'h100, 32'h0, 1'b0, 2, 32'h8877_ABF0};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 14'h101, 32'hFFFF_FFFF, 1'b1, 1, 32'h8877_ABF0};
    vt[8]  = '{1'b0, 2'd2, 1'b0, 14'h102, 32'h0, 1'b1, 1, 32'h8877_ABF0};
    vt[9]  = '{1'b0, 2'd3, 1'b0, 14'h100, 32'h0, 1'b1, 1, 32'h8877_ABF0};
    vt[10] = '{1'b1, 2'd3, 1'b0, 14'h100, 32'hFFFF_FFFF, 1'b1, 1, 32'h8877_ABF0};
    vt[11] = '{1'b0, 2'd2, 1'b0, 14'h100, 32'h0, 1'b0, 2, 32'h8877_ABF0};
    vt[12] = '{1'b1, 2'd1, 1'b0, 14'h102, 32'h1111_CAFE, 1'b0, 3, 32'h8877_ABF0};
    vt[13] = '{1'b0, 2'd0, 1'b1, 14'h103, 32'h0, 1'b0, 2, 32'hFFFF_FFCA};
    vt[14] = '{1'b0, 2'd2, 1'b0, 14'h100, 32'h0, 1'b0, 2, 32'hCAFE_ABF0};
    vt[15] = '{1'b0, 2'd1, 1'b1, 14'h100, 32'h0, 1'b0, 2, 32'hFFFF_ABF0};
    for (int i = 0; i < 16; i++) begin
      do_req(vt[i].st, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd, lat, flt, rd, nrd, nwr);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].el);
      chk($sformatf("vec%0d_fault", i), {31'd0, flt}, {31'd0, vt[i].ef});
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].er);
      chk($sformatf("vec%0d_writes", i), nwr, (vt[i].st && !vt[i].ef) ? 1 : 0);
      if (vt[i].ef) chk($sformatf("vec%0d_reads", i), nrd, 0);
      model_apply(vt[i].st, vt[i].sz, vt[i].sg, vt[i].a, vt[i].wd);
      m_rdata = vt[i].er;
    end

    // SW at top of memory with req_valid held high while busy
    a0 = acc_cnt;
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 14'h3FFC; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_store = 1'b0; req_addr = 14'h0000;
    lat = 1;
    while (!resp_done && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    req_valid = 1'b0;
    chk("hold_sw_lat", lat, 2);
    @(posedge clk); #1;
    chk("hold_accepts", acc_cnt - a0, 1);
    ref_mem[12'hFFF] = 32'hDEAD_BEEF;
    run_model("top_lw", 1'b0, 2'd2, 1'b0, 14'h3FFC, 32'h0);
    chk("top_lw_value", m_rdata, 32'hDEAD_BEEF);

    // Reset while in RMW_RD of SB 0x104
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 14'h104; req_wdata = 32'h0000_0055;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rd_reading", {31'd0, dmem_read}, 32'd1);
    w0 = wr_cnt;
    rst_n = 1'b0; #1;
    chk("abort_read", {31'd0, dmem_read}, 32'd0);
    chk("abort_write", {31'd0, dmem_write}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_done", {31'd0, resp_done}, 32'd0);
    chk("abort_rdata", resp_rdata, 32'd0);
    m_rdata = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_word_kept", mem[12'h041], ref_mem[12'h041]);
    run_model("post_abort_lw", 1'b0, 2'd2, 1'b0, 14'h104, 32'h0);

    // Randomized requests against the reference model
    for (int i = 0; i < 200; i++) begin
      idx = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 127));
      ra  = {idx, 2'($urandom_range(0, 3))};
      run_model("rand", 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), ra, $urandom);
    end

    // Final memory image and read/write exclusivity
    for (int i = 0; i < 129; i++) begin
      idx = (i == 128) ? 12'hFFF : 12'(i);
      chk($sformatf("mem_%03h", idx), mem[idx], ref_mem[idx]);
    end
    chk("rd_wr_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
